// File: rtl/cmd_issue_ctrl.sv
// SD CMD-line issue sequencer: grants software/Auto CMD12 requests, drives the serialiser,
// supervises the response window with a timeout and enforces the Ncc idle gap afterwards.
module cmd_issue_ctrl #(
   parameter int unsigned RspTimeout = 64,
   parameter int unsigned NccCycles  = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clk_en_p_i,
   input  logic        cmd_reset_i,
   input  logic        sw_req_i,
   input  logic [5:0]  sw_cmd_nr_i,
   input  logic [31:0] sw_arg_i,
   input  logic [1:0]  sw_rsp_type_i,
   output logic        sw_gnt_o,
   input  logic        auto_req_i,
   output logic        auto_gnt_o,
   output logic        start_tx_o,
   output logic [5:0]  cmd_nr_o,
   output logic [31:0] cmd_arg_o,
   input  logic        tx_done_i,
   output logic        rsp_en_o,
   output logic        rsp_long_o,
   input  logic        rsp_start_i,
   input  logic        rsp_done_i,
   input  logic        rsp_err_i,
   output logic        cmd_inhibit_o,
   output logic        cmd_cplt_o,
   output logic        auto_cplt_o,
   output logic        timeout_err_o,
   output logic        rsp_err_o
);

   localparam int unsigned CntMax = (RspTimeout > NccCycles) ? RspTimeout : NccCycles;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam logic [CntW-1:0] RspTerm = CntW'(RspTimeout);
   localparam logic [CntW-1:0] NccTerm = CntW'(NccCycles);

   typedef enum logic [2:0] {IDLE, START, TX, RSP, GAP} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
   logic              started_q, started_d;
   logic              auto_q, auto_d;
   logic [1:0]        type_q, type_d;
   logic [5:0]        nr_q, nr_d;
   logic [31:0]       arg_q, arg_d;

   assign cnt_inc = cnt_q + CntW'(1);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      started_d     = started_q;
      auto_d        = auto_q;
      type_d        = type_q;
      nr_d          = nr_q;
      arg_d         = arg_q;
      sw_gnt_o      = 1'b0;
      auto_gnt_o    = 1'b0;
      cmd_cplt_o    = 1'b0;
      timeout_err_o = 1'b0;
      rsp_err_o     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (clk_en_p_i && auto_req_i) begin
               auto_gnt_o = 1'b1;
               nr_d       = 6'd12;
               arg_d      = 32'd0;
               type_d     = 2'b10;
               auto_d     = 1'b1;
               state_d    = START;
            end else if (clk_en_p_i && sw_req_i) begin
               sw_gnt_o = 1'b1;
               nr_d     = sw_cmd_nr_i;
               arg_d    = sw_arg_i;
               type_d   = sw_rsp_type_i;
               auto_d   = 1'b0;
               state_d  = START;
            end
         end
         START: begin
            // serialiser has accepted the command once its idle flag drops
            if (!tx_done_i) state_d = TX;
         end
         TX: begin
            if (tx_done_i) begin
               cnt_d     = '0;
               started_d = 1'b0;
               if (type_q != 2'b00) begin
                  state_d = RSP;
               end else begin
                  cmd_cplt_o = 1'b1;
                  state_d    = GAP;
               end
            end
         end
         RSP: begin
            if (rsp_done_i) begin
               rsp_err_o  = rsp_err_i;
               cmd_cplt_o = !rsp_err_i;
               cnt_d      = '0;
               state_d    = GAP;
            end else if (started_q || rsp_start_i) begin
               // a start bit on the terminal tick still counts as in time
               started_d = 1'b1;
            end else if (clk_en_p_i) begin
               if (cnt_inc == RspTerm) begin
                  timeout_err_o = 1'b1;
                  cnt_d         = '0;
                  state_d       = GAP;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         GAP: begin
            if (clk_en_p_i) begin
               if (cnt_inc == NccTerm) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      auto_cplt_o = cmd_cplt_o & auto_q;

      if (cmd_reset_i) begin
         state_d       = IDLE;
         cnt_d         = '0;
         started_d     = 1'b0;
         auto_d        = 1'b0;
         type_d        = 2'b00;
         nr_d          = 6'd0;
         arg_d         = 32'd0;
         sw_gnt_o      = 1'b0;
         auto_gnt_o    = 1'b0;
         cmd_cplt_o    = 1'b0;
         auto_cplt_o   = 1'b0;
         timeout_err_o = 1'b0;
         rsp_err_o     = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         started_q <= 1'b0;
         auto_q    <= 1'b0;
         type_q    <= 2'b00;
         nr_q      <= 6'd0;
         arg_q     <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         started_q <= started_d;
         auto_q    <= auto_d;
         type_q    <= type_d;
         nr_q      <= nr_d;
         arg_q     <= arg_d;
      end
   end

   assign start_tx_o    = (state_q == START);
   assign rsp_en_o      = (state_q == RSP);
   assign rsp_long_o    = (state_q == RSP) && (type_q == 2'b01);
   assign cmd_inhibit_o = (state_q != IDLE);
   assign cmd_nr_o      = nr_q;
   assign cmd_arg_o     = arg_q;

endmodule

// File: tb/tb_cmd_issue_ctrl.sv
// Bench for cmd_issue_ctrl: cycle table for a CMD0 issue, directed corner sequences and
// randomized commands checked against a transaction-level expectation of each command.
module tb_cmd_issue_ctrl;

   localparam int RSP_TO = 64;
   localparam int NCC    = 8;

   logic        clk_i = 1'b0;
   logic        rst_ni, clk_en_p_i, cmd_reset_i;
   logic        sw_req_i, auto_req_i, sw_gnt_o, auto_gnt_o;
   logic [5:0]  sw_cmd_nr_i, cmd_nr_o;
   logic [31:0] sw_arg_i, cmd_arg_o;
   logic [1:0]  sw_rsp_type_i;
   logic        start_tx_o, tx_done_i, rsp_en_o, rsp_long_o;
   logic        rsp_start_i, rsp_done_i, rsp_err_i;
   logic        cmd_inhibit_o, cmd_cplt_o, auto_cplt_o, timeout_err_o, rsp_err_o;

   cmd_issue_ctrl #(.RspTimeout(RSP_TO), .NccCycles(NCC)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clk_en_p_i(clk_en_p_i), .cmd_reset_i(cmd_reset_i),
      .sw_req_i(sw_req_i), .sw_cmd_nr_i(sw_cmd_nr_i), .sw_arg_i(sw_arg_i),
      .sw_rsp_type_i(sw_rsp_type_i), .sw_gnt_o(sw_gnt_o), .auto_req_i(auto_req_i),
      .auto_gnt_o(auto_gnt_o), .start_tx_o(start_tx_o), .cmd_nr_o(cmd_nr_o),
      .cmd_arg_o(cmd_arg_o), .tx_done_i(tx_done_i), .rsp_en_o(rsp_en_o),
      .rsp_long_o(rsp_long_o), .rsp_start_i(rsp_start_i), .rsp_done_i(rsp_done_i),
      .rsp_err_i(rsp_err_i), .cmd_inhibit_o(cmd_inhibit_o), .cmd_cplt_o(cmd_cplt_o),
      .auto_cplt_o(auto_cplt_o), .timeout_err_o(timeout_err_o), .rsp_err_o(rsp_err_o)
   );

   always #5 clk_i = ~clk_i;

   // pulse order: sw_gnt, auto_gnt, cplt, auto_cplt, timeout, rsp_err
   wire [5:0] pls  = {sw_gnt_o, auto_gnt_o, cmd_cplt_o, auto_cplt_o, timeout_err_o, rsp_err_o};
   wire [9:0] outs = {pls, start_tx_o, rsp_en_o, rsp_long_o, cmd_inhibit_o};

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct packed {
      bit ce, req, td;
      bit gnt, st, en, inh, cp;
   } vec_t;
   vec_t tbl [18];
   bit   gap_ce [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_bound(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: DUT event not seen within cycle budget at %0t", name, $time);
   endtask

   task automatic next_cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic samp();
      #4;
   endtask

   function automatic bit rce();
      return ($urandom_range(0, 2) != 0);
   endfunction

   // One full command. start_at: RSP tick on which rsp_start_i is driven (> RSP_TO = never).
   task automatic run_cmd(input bit use_auto, input bit use_sw, input logic [5:0] nr,
                          input logic [31:0] arg, input logic [1:0] typ,
                          input int start_at, input bit err);
      logic [5:0]  enr;
      logic [31:0] earg;
      logic [1:0]  etyp;
      bit granted, started, done, ce, do_start, do_done, exp_to;
      int ticks, dw, gt;
      enr  = use_auto ? 6'd12 : nr;
      earg = use_auto ? 32'd0 : arg;
      etyp = use_auto ? 2'b10 : typ;
      sw_cmd_nr_i = nr; sw_arg_i = arg; sw_rsp_type_i = typ;

      granted = 1'b0;
      for (int c = 0; c < 100 && !granted; c++) begin
         next_cyc();
         auto_req_i = use_auto; sw_req_i = use_sw;
         ce = rce(); clk_en_p_i = ce;
         samp();
         chk("idle_inhibit", cmd_inhibit_o, 0);
         chk("grant", pls, {ce && use_sw && !use_auto, ce && use_auto, 4'b0});
         granted = ce;
      end
      if (!granted) begin fail_bound("grant_wait"); return; end

      next_cyc();
      auto_req_i = 1'b0; sw_req_i = use_sw && use_auto; clk_en_p_i = rce();
      samp();
      chk("start_tx", {start_tx_o, cmd_inhibit_o}, 2'b11);
      chk("cmd_nr", cmd_nr_o, enr);
      chk("cmd_arg", cmd_arg_o, earg);
      repeat ($urandom_range(0, 2)) begin
         next_cyc(); clk_en_p_i = rce(); samp();
         chk("start_hold", start_tx_o, 1);
      end
      next_cyc(); tx_done_i = 1'b0; clk_en_p_i = rce(); samp();
      chk("start_fall", start_tx_o, 1);
      repeat ($urandom_range(1, 3)) begin
         next_cyc(); clk_en_p_i = rce(); samp();
         chk("tx_busy", {start_tx_o, rsp_en_o, pls}, 0);
      end
      next_cyc(); tx_done_i = 1'b1; clk_en_p_i = rce(); samp();
      chk("tx_end", {rsp_en_o, pls},
          {1'b0, 2'b00, etyp == 2'b00, (etyp == 2'b00) && use_auto, 2'b00});

      if (etyp != 2'b00) begin
         ticks = 0; started = 1'b0; done = 1'b0; dw = 0;
         for (int c = 0; c < 1000 && !done; c++) begin
            next_cyc();
            ce = rce(); clk_en_p_i = ce;
            do_start = 1'b0; do_done = 1'b0;
            if (started) begin
               if (dw == 0) do_done = 1'b1;
               else dw--;
            end else if (ce) begin
               ticks++;
               if (ticks == start_at) begin
                  do_start = 1'b1; started = 1'b1; dw = $urandom_range(0, 3);
               end
            end
            rsp_start_i = do_start; rsp_done_i = do_done; rsp_err_i = do_done && err;
            exp_to = !started && ce && (ticks == RSP_TO);
            samp();
            chk("rsp_en", {rsp_en_o, rsp_long_o}, {1'b1, etyp == 2'b01});
            chk("rsp_pulses", pls, {2'b00, do_done && !err, do_done && !err && use_auto,
                                    exp_to, do_done && err});
            done = do_done || exp_to;
         end
         if (!done) fail_bound("rsp_wait");
      end

      gt = 0;
      for (int c = 0; c < 1000 && gt < NCC; c++) begin
         next_cyc();
         rsp_start_i = 1'b0; rsp_done_i = 1'b0; rsp_err_i = 1'b0;
         ce = rce(); clk_en_p_i = ce;
         samp();
         chk("gap", {cmd_inhibit_o, start_tx_o, rsp_en_o, pls}, {1'b1, 8'b0});
         if (ce) gt++;
      end
      if (gt < NCC) fail_bound("gap_wait");
   endtask

   bit          r_auto, r_sw, r_err;
   logic [5:0]  r_nr;
   logic [31:0] r_arg;
   logic [1:0]  r_typ;
   int          r_st;

   initial begin
      tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      gap_ce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 11; i++)
         tbl[6+i] = '{gap_ce[i], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      rst_ni = 1'b0; clk_en_p_i = 1'b0; cmd_reset_i = 1'b0;
      sw_req_i = 1'b0; auto_req_i = 1'b0; sw_cmd_nr_i = 6'd0; sw_arg_i = 32'd0;
      sw_rsp_type_i = 2'b00; tx_done_i = 1'b1;
      rsp_start_i = 1'b0; rsp_done_i = 1'b0; rsp_err_i = 1'b0;
      repeat (3) next_cyc();
      samp();
      chk("reset_outs", outs, 0);
      chk("reset_nr_arg", {cmd_nr_o, cmd_arg_o[25:0]}, 0);
      next_cyc();
      rst_ni = 1'b1;

      // CMD0, no response, with clk_en gating of the grant and the Ncc gap
      for (int i = 0; i < 18; i++) begin
         next_cyc();
         clk_en_p_i = tbl[i].ce; sw_req_i = tbl[i].req; tx_done_i = tbl[i].td;
         samp();
         chk($sformatf("tbl[%0d]", i), {sw_gnt_o, start_tx_o, rsp_en_o, cmd_inhibit_o, cmd_cplt_o},
             {tbl[i].gnt, tbl[i].st, tbl[i].en, tbl[i].inh, tbl[i].cp});
      end

      run_cmd(1'b0, 1'b1, 6'd17, 32'h0000_0200, 2'b10, 5, 1'b0);
      run_cmd(1'b1, 1'b1, 6'd18, 32'h0000_1234, 2'b01, 3, 1'b0);
      run_cmd(1'b0, 1'b1, 6'd18, 32'h0000_1234, 2'b01, 3, 1'b0);
      run_cmd(1'b0, 1'b1, 6'd17, 32'hDEAD_0000, 2'b10, 1000, 1'b0);
      run_cmd(1'b0, 1'b1, 6'd2, 32'h0, 2'b01, 10, 1'b1);
      run_cmd(1'b0, 1'b1, 6'd0, 32'h0, 2'b00, 0, 1'b0);
      run_cmd(1'b0, 1'b1, 6'd13, 32'h55, 2'b11, RSP_TO, 1'b0);

      // cmd_reset_i while TX would otherwise complete a no-response command
      next_cyc();
      sw_cmd_nr_i = 6'd5; sw_arg_i = 32'hAAAA; sw_rsp_type_i = 2'b00;
      sw_req_i = 1'b1; clk_en_p_i = 1'b1;
      samp(); chk("cr_gnt", sw_gnt_o, 1);
      next_cyc(); sw_req_i = 1'b0; tx_done_i = 1'b0; clk_en_p_i = 1'b0;
      samp(); chk("cr_start", start_tx_o, 1);
      next_cyc(); samp(); chk("cr_tx", {start_tx_o, cmd_inhibit_o}, 2'b01);
      next_cyc(); cmd_reset_i = 1'b1; tx_done_i = 1'b1;
      samp(); chk("cr_nopulse", pls, 0);
      next_cyc(); cmd_reset_i = 1'b0;
      samp(); chk("cr_idle", outs, 0); chk("cr_nr_arg", {cmd_nr_o, cmd_arg_o[25:0]}, 0);

      // async reset in the middle of a long-response window, with rsp_done_i racing it
      next_cyc();
      sw_cmd_nr_i = 6'd9; sw_arg_i = 32'h77; sw_rsp_type_i = 2'b01;
      sw_req_i = 1'b1; clk_en_p_i = 1'b1;
      samp(); chk("ar_gnt", sw_gnt_o, 1);
      next_cyc(); sw_req_i = 1'b0; tx_done_i = 1'b0; samp();
      next_cyc(); tx_done_i = 1'b1; clk_en_p_i = 1'b0; samp();
      next_cyc(); samp(); chk("ar_rsp", {rsp_en_o, rsp_long_o}, 2'b11);
      next_cyc(); rst_ni = 1'b0; rsp_done_i = 1'b1;
      #1; chk("ar_idle", outs, 0); chk("ar_nr_arg", {cmd_nr_o, cmd_arg_o[25:0]}, 0);
      next_cyc(); rsp_done_i = 1'b0;
      next_cyc(); rst_ni = 1'b1;
      run_cmd(1'b0, 1'b1, 6'd9, 32'h77, 2'b01, 4, 1'b0);

      for (int k = 0; k < 30; k++) begin
         r_auto = ($urandom_range(0, 3) == 0);
         r_sw   = r_auto ? 1'($urandom_range(0, 1)) : 1'b1;
         r_nr   = 6'($urandom);
         r_arg  = $urandom;
         r_typ  = 2'($urandom);
         r_st   = ($urandom_range(0, 4) == 0) ? RSP_TO + 10 : $urandom_range(1, RSP_TO);
         r_err  = ($urandom_range(0, 3) == 0);
         run_cmd(r_auto, r_sw, r_nr, r_arg, r_typ, r_st, r_err);
         if (r_auto && r_sw)
            run_cmd(1'b0, 1'b1, r_nr, r_arg, r_typ, $urandom_range(1, 20), 1'b0);
      end

      next_cyc(); sw_req_i = 1'b0; clk_en_p_i = 1'b1;
      samp(); chk("final_idle", outs, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
